dm_sequencer: RTL and testbench
===============================

// Module: dm_sequencer
// PURPOSE
//  Control stage directly upstream of data_mem in each PE. Holds a small instruction
//  memory, registers load/shift/TX data into data_mem and issues one instruction per cycle.
//  Drives rden, inst_v/inst, shift_v and a latency-matched wed write-back strobe.
//  Guarantees wea/web/wec/wed are mutually exclusive; data_mem relies on this.
// PARAMETERS
//  DATA_WIDTH  16  real/imag component width; data bus is 2*DATA_WIDTH
//  INST_WIDTH  32  instruction width; [23:16] src2, [15:8] src1, [7:0] dest
//  IM_DEPTH    16  instruction memory entries (power of 2)
//  WB_LAT      6   cycles from inst_v to wed (2 BRAM read + ALU pipe); must be >= 1
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous reset, active-high
//  im_wr_v      in   1               instruction write strobe (accepted in IDLE only)
//  im_wr_data   in   INST_WIDTH      instruction to append at im_wptr
//  data_in_v    in   1               data word valid
//  data_in_sel  in   2               00 LOAD(wea), 01 SHIFT(web), 10 TX(wec), 11 dropped
//  data_in      in   2*DATA_WIDTH    data word
//  data_in_rdy  out  1               1 only in IDLE; transfer = data_in_v & data_in_rdy
//  start        in   1               run-program pulse (accepted in IDLE only)
//  shift_len    in   8               shift_v cycles after program; sampled at start
//  wea,web,wec  out  1               data_mem write strobes (one-hot or zero)
//  wed          out  1               data_mem write-back strobe
//  dina         out  2*DATA_WIDTH    registered data_in
//  rden         out  1               data_mem read enable
//  inst_v       out  1               instruction valid
//  inst         out  INST_WIDTH      instruction
//  shift_v      out  1               shift-read valid
//  done         out  1               one-cycle pulse at end of run
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; im_wptr=0; pc=0; wb_pipe cleared. IM contents kept.
//  FSM: IDLE -> EXEC (start & im_wptr!=0) -> DRAIN -> SHIFT (shift_len!=0) | DONE -> IDLE.
//   start with im_wptr==0: DONE next cycle, no issue. start outside IDLE: ignored.
//  IM write: im_wr_v in IDLE stores at im_wptr, im_wptr++; at IM_DEPTH further writes are
//   dropped (no wrap); im_wptr clears on DONE. im_wr_v outside IDLE: dropped.
//  Data path: accepted word -> strobe per sel and dina valid next cycle (latency 1);
//   sel=11 produces no strobe. data_in_v while not IDLE: not accepted, no strobe.
//  EXEC: per cycle inst_v=1, inst=IM[pc], pc++; after pc==im_wptr-1 -> DRAIN. Back-to-back.
//  wed = inst_v delayed exactly WB_LAT cycles (shift register); one wed per inst_v.
//  DRAIN: lasts WB_LAT cycles so last wed falls inside it; then SHIFT or DONE.
//  SHIFT: shift_v=1 for shift_len cycles (latched len, 8-bit down counter), then DONE.
//  rden=1 in EXEC, DRAIN, SHIFT; 0 otherwise.
//  DONE: done=1 one cycle, pc=0, -> IDLE.
//  Reset mid-run: outputs 0 next cycle, pending wed pulses discarded, back to IDLE.
// STRUCTURE
//  Shared package/header (parameters.vh): DATA_WIDTH, INST_WIDTH, field bit positions,
//   data_in_sel encodings, FSM state encodings, WB_LAT default.
//  One natural sub-module: dm_wb_delay (WB_LAT-deep 1-bit shift register with sync clear).
//  IM as distributed-RAM register array; single always block for FSM/counters.
// TESTING
//  Reset: all outputs 0, data_in_rdy=1 on first cycle after rst deassert.
//  Load 3 words sel=00 (0x11110000..) -> wea high 3 cycles, dina matches, 1 cycle later.
//  sel=01,10,11 one each -> web then wec then none; never two strobes high at once.
//  Write 4 insts, start, shift_len=0 -> inst_v 4 cycles in order, wed 4 cycles starting
//   WB_LAT=6 after first inst_v, done once after last wed, rdy low throughout.
//  Same program, shift_len=5 -> 5 shift_v cycles after DRAIN, then done.
//  rst asserted 2 cycles into EXEC -> no further inst_v/wed; IDLE; restart runs cleanly.

Source files
------------

// File: rtl/dm_sequencer_pkg.sv
// dm_sequencer_pkg
//   Shared definitions for the data_mem sequencer: bus widths, instruction
//   field layout, data_in_sel encodings, FSM state encoding and the
//   write-back latency between an issued instruction and its wed strobe.
package dm_sequencer_pkg;

  localparam int DATA_WIDTH = 16;  // real/imag component width
  localparam int INST_WIDTH = 32;  // instruction width
  localparam int IM_DEPTH   = 16;  // instruction memory entries (power of 2)
  localparam int WB_LAT     = 6;   // 2 BRAM read + ALU pipe; must be >= 1

  // Instruction field layout: [23:16] src2, [15:8] src1, [7:0] dest.
  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] src2;
    logic [7:0] src1;
    logic [7:0] dest;
  } dm_inst_t;

  // data_in_sel encodings.
  typedef enum logic [1:0] {
    SEL_LOAD  = 2'b00,  // wea
    SEL_SHIFT = 2'b01,  // web
    SEL_TX    = 2'b10,  // wec
    SEL_DROP  = 2'b11   // no strobe
  } dm_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } dm_state_e;

endpackage

// File: rtl/dm_sequencer_wb_delay.sv
// dm_wb_delay
//   DEPTH-deep 1-bit shift register with synchronous clear. Delays the
//   instruction-valid strobe so the write-back strobe lines up with the
//   result leaving the BRAM read + ALU pipeline.
// Ports
//   clk   in  clock
//   rst   in  synchronous clear, active-high (drops pulses in flight)
//   din   in  strobe to delay
//   dout  out din delayed exactly DEPTH cycles
module dm_wb_delay #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(din);
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dm_sequencer.sv
// dm_sequencer
//   Control stage directly upstream of data_mem. Registers load/shift/TX
//   words into data_mem, holds a small instruction memory and, on start,
//   issues its program one instruction per cycle, waits for the last
//   write-back, optionally streams shift_v for shift_len cycles, then pulses
//   done. wea/web/wec/wed are never high together: data words are only
//   accepted in IDLE and every wed lands before the run returns to IDLE.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   im_wr_v, im_wr_data      append instruction at im_wptr (IDLE only)
//   data_in_v/_sel/data_in   data word and its destination select
//   data_in_rdy              high only in IDLE (and not in reset)
//   start, shift_len         run request; shift_len sampled with start
//   wea, web, wec, dina      registered data_mem write strobes and data
//   wed                      write-back strobe, inst_v delayed WB_LAT cycles
//   rden, inst_v, inst       data_mem read enable and issued instruction
//   shift_v, done            shift-read valid, end-of-run pulse
//   state_dbg                current FSM state
//
// Handshake: a data word transfers in the cycle where data_in_v and
// data_in_rdy are both high; data_in_v without data_in_rdy is simply not
// taken (no strobe) and the sender is not required to hold it.
module dm_sequencer
  import dm_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    im_wr_v,
  input  logic [INST_WIDTH-1:0]   im_wr_data,
  input  logic                    data_in_v,
  input  logic [1:0]              data_in_sel,
  input  logic [2*DATA_WIDTH-1:0] data_in,
  output logic                    data_in_rdy,
  input  logic                    start,
  input  logic [7:0]              shift_len,
  output logic                    wea,
  output logic                    web,
  output logic                    wec,
  output logic                    wed,
  output logic [2*DATA_WIDTH-1:0] dina,
  output logic                    rden,
  output logic                    inst_v,
  output logic [INST_WIDTH-1:0]   inst,
  output logic                    shift_v,
  output logic                    done,
  output dm_state_e               state_dbg
);

  localparam int PC_W = $clog2(IM_DEPTH);
  localparam int DR_W = $clog2(WB_LAT + 1);

  dm_state_e             state, state_nxt;
  logic [PC_W-1:0]       pc;
  logic [PC_W:0]         im_wptr;     // one extra bit so "full" is representable
  logic [DR_W-1:0]       drain_cnt;
  logic [7:0]            shift_cnt;   // holds latched shift_len until SHIFT
  logic [INST_WIDTH-1:0] im [IM_DEPTH];

  logic in_idle, data_xfer, im_wr_ok, last_inst;

  assign in_idle     = (state == ST_IDLE);
  assign data_in_rdy = in_idle & ~rst;
  assign data_xfer   = data_in_v & data_in_rdy;
  assign im_wr_ok    = in_idle & im_wr_v & (im_wptr != (PC_W+1)'(IM_DEPTH));
  assign last_inst   = ({1'b0, pc} == (im_wptr - 1'b1));
  assign state_dbg   = state;

  // State register and run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      im_wptr   <= '0;
      drain_cnt <= '0;
      shift_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (im_wr_ok)         im_wptr   <= im_wptr + 1'b1;
      if (in_idle && start) shift_cnt <= shift_len;
      case (state)
        ST_EXEC: begin
          pc        <= pc + 1'b1;
          // Reloaded every issue cycle; the final load starts the drain.
          drain_cnt <= DR_W'(WB_LAT - 1);
        end
        ST_DRAIN: drain_cnt <= drain_cnt - 1'b1;
        ST_SHIFT: shift_cnt <= shift_cnt - 1'b1;
        ST_DONE: begin
          pc      <= '0;
          im_wptr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (im_wptr != '0) ? ST_EXEC : ST_DONE;
      ST_EXEC:  if (last_inst) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == '0)
                  state_nxt = (shift_cnt != 8'd0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (shift_cnt == 8'd1) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    rden    = 1'b0;
    inst_v  = 1'b0;
    shift_v = 1'b0;
    done    = 1'b0;
    case (state)
      ST_EXEC:  begin rden = 1'b1; inst_v = 1'b1; end
      ST_DRAIN: rden = 1'b1;
      ST_SHIFT: begin rden = 1'b1; shift_v = 1'b1; end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign inst = inst_v ? im[pc] : '0;

  // Instruction memory: distributed RAM, contents survive reset.
  always_ff @(posedge clk) begin
    if (im_wr_ok) im[im_wptr[PC_W-1:0]] <= im_wr_data;
  end

  // Data path: one registered strobe per accepted word, SEL_DROP gives none.
  always_ff @(posedge clk) begin
    if (rst) begin
      wea  <= 1'b0;
      web  <= 1'b0;
      wec  <= 1'b0;
      dina <= '0;
    end else begin
      wea <= data_xfer && (data_in_sel == SEL_LOAD);
      web <= data_xfer && (data_in_sel == SEL_SHIFT);
      wec <= data_xfer && (data_in_sel == SEL_TX);
      if (data_xfer) dina <= data_in;
    end
  end

  dm_wb_delay #(.DEPTH(WB_LAT)) u_wb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (inst_v),
    .dout (wed)
  );

endmodule

// File: tb/tb_dm_sequencer.sv
module tb_dm_sequencer;
  import dm_sequencer_pkg::*;

  localparam int DW2 = 2 * DATA_WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  im_wr_v;
  logic [INST_WIDTH-1:0] im_wr_data;
  logic                  data_in_v;
  logic [1:0]            data_in_sel;
  logic [DW2-1:0]        data_in;
  logic                  data_in_rdy;
  logic                  start;
  logic [7:0]            shift_len;
  logic                  wea, web, wec, wed;
  logic [DW2-1:0]        dina;
  logic                  rden, inst_v;
  logic [INST_WIDTH-1:0] inst;
  logic                  shift_v, done;
  dm_state_e             state_dbg;

  dm_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .im_wr_v     (im_wr_v),
    .im_wr_data  (im_wr_data),
    .data_in_v   (data_in_v),
    .data_in_sel (data_in_sel),
    .data_in     (data_in),
    .data_in_rdy (data_in_rdy),
    .start       (start),
    .shift_len   (shift_len),
    .wea         (wea),
    .web         (web),
    .wec         (wec),
    .wed         (wed),
    .dina        (dina),
    .rden        (rden),
    .inst_v      (inst_v),
    .inst        (inst),
    .shift_v     (shift_v),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW2+2:0] stim_q[$];  // {valid, sel, data} per cycle
  logic [DW2+2:0] exp_q[$];   // words in flight, checked one cycle later

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic e_iv, input logic [INST_WIDTH-1:0] e_inst,
                             input logic e_wed, input logic e_rden, input logic e_shv,
                             input logic e_done, input logic e_rdy);
    chk({tag, " inst_v"},  64'(inst_v), 64'(e_iv));
    chk({tag, " inst"},    64'(inst), 64'(e_inst));
    chk({tag, " wed"},     64'(wed), 64'(e_wed));
    chk({tag, " rden"},    64'(rden), 64'(e_rden));
    chk({tag, " shift_v"}, 64'(shift_v), 64'(e_shv));
    chk({tag, " done"},    64'(done), 64'(e_done));
    chk({tag, " rdy"},     64'(data_in_rdy), 64'(e_rdy));
    chk({tag, " strobes"}, 64'({wea, web, wec}), 64'(0));
  endtask

  // ---------------- driver: data words ----------------
  task automatic play_words();
    logic [DW2+2:0] cur, e;
    int n;
    n = stim_q.size();
    for (int i = 0; i <= n; i++) begin
      cur = (i < n) ? stim_q[i] : '0;
      @(posedge clk); #1;
      data_in_v   = cur[DW2+2];
      data_in_sel = cur[DW2+1:DW2];
      data_in     = cur[DW2-1:0];
      exp_q.push_back(cur);
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("word%0d wea", i-1), 64'(wea), 64'(e[DW2+2] && e[DW2+1:DW2] == 2'b00));
        chk($sformatf("word%0d web", i-1), 64'(web), 64'(e[DW2+2] && e[DW2+1:DW2] == 2'b01));
        chk($sformatf("word%0d wec", i-1), 64'(wec), 64'(e[DW2+2] && e[DW2+1:DW2] == 2'b10));
        if (e[DW2+2] && e[DW2+1:DW2] != 2'b11)
          chk($sformatf("word%0d dina", i-1), 64'(dina), 64'(e[DW2-1:0]));
        chk("word onehot", 64'($countones({wea, web, wec, wed}) <= 1), 64'(1));
      end
      chk("word rdy", 64'(data_in_rdy), 64'(1));
    end
    @(posedge clk); #1;
    data_in_v = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver: program run ----------------
  // Writes nwr random instructions, starts with shift_len slen and checks every
  // cycle against the run timeline. rst_at != 0 pulses reset in that cycle.
  task automatic run_prog(input int nwr, input int slen, input int rst_at);
    logic [INST_WIDTH-1:0] im_m[$];
    int n, done_k, end_k;
    logic iv, busy;
    string tag;
    im_m = {};
    for (int i = 0; i < nwr; i++) begin
      @(posedge clk); #1;
      im_wr_v    = 1'b1;
      im_wr_data = $urandom();
      if (im_m.size() < IM_DEPTH) im_m.push_back(im_wr_data);
    end
    @(posedge clk); #1;
    im_wr_v   = 1'b0;
    start     = 1'b1;
    shift_len = 8'(slen);
    n      = im_m.size();
    done_k = (n == 0) ? 1 : n + WB_LAT + slen + 1;
    end_k  = (rst_at != 0) ? rst_at + WB_LAT + 2 : done_k + 1;
    @(posedge clk); #1;
    start     = 1'b0;
    shift_len = 8'($urandom());  // must not matter after start
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      tag = $sformatf("run n=%0d len=%0d k=%0d", n, slen, k);
      if (rst_at != 0 && k > rst_at)
        check_cycle({tag, " after_rst"}, 0, '0, 0, 0, 0, 0, 1);
      else if (n == 0)
        check_cycle({tag, " empty"}, 0, '0, 0, 0, 0, k == 1, k > 1);
      else begin
        iv = (k <= n);
        check_cycle(tag, iv, iv ? im_m[k-1] : '0,
                    (k > WB_LAT && k <= n + WB_LAT),
                    (k <= n + WB_LAT + slen),
                    (k > n + WB_LAT && k <= n + WB_LAT + slen),
                    (k == done_k), (k > done_k));
      end
      chk("run onehot", 64'($countones({wea, web, wec, wed}) <= 1), 64'(1));
      if (k < end_k) begin
        @(posedge clk); #1;
        rst  = (rst_at != 0 && k + 1 == rst_at);
        busy = (rst_at != 0) ? (k + 1 <= rst_at) : (k + 1 <= done_k);
        if (busy) begin
          // Everything driven here must be ignored by a busy sequencer.
          data_in_v   = 1'($urandom_range(0, 1));
          data_in_sel = 2'($urandom_range(0, 3));
          data_in     = $urandom();
          start       = 1'($urandom_range(0, 1));
          im_wr_v     = 1'($urandom_range(0, 1));
          im_wr_data  = $urandom();
        end else begin
          data_in_v = 1'b0;
          start     = 1'b0;
          im_wr_v   = 1'b0;
        end
      end
    end
    rst       = 1'b0;
    data_in_v = 1'b0;
    start     = 1'b0;
    im_wr_v   = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; im_wr_v = 1'b0; im_wr_data = '0; data_in_v = 1'b0;
    data_in_sel = '0; data_in = '0; start = 1'b0; shift_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cycle("in_reset", 0, '0, 0, 0, 0, 0, 0);
    chk("in_reset dina", 64'(dina), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_cycle("post_reset", 0, '0, 0, 0, 0, 0, 1);

    // Directed words: three loads, then one of each other select.
    for (int i = 0; i < 3; i++) stim_q.push_back({1'b1, 2'b00, DW2'(32'h1111_0000 + i)});
    stim_q.push_back({1'b1, 2'b01, DW2'($urandom())});
    stim_q.push_back({1'b1, 2'b10, DW2'($urandom())});
    stim_q.push_back({1'b1, 2'b11, DW2'($urandom())});
    play_words();
    for (int i = 0; i < 24; i++)
      stim_q.push_back({1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DW2'($urandom())});
    play_words();

    run_prog(4, 0, 0);        // basic run, no shift
    run_prog(4, 5, 0);        // with shift phase
    run_prog(0, 3, 0);        // empty program: immediate done
    run_prog(IM_DEPTH + 2, 2, 0);  // extra writes beyond IM_DEPTH dropped
    run_prog(1, 255, 0);      // single instruction, maximum shift_len
    run_prog(4, 0, 3);        // reset two cycles into EXEC
    run_prog(4, 3, 0);        // clean restart
    for (int r = 0; r < 4; r++)
      run_prog($urandom_range(1, IM_DEPTH), $urandom_range(0, 10), 0);

    for (int i = 0; i < 16; i++)
      stim_q.push_back({1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DW2'($urandom())});
    play_words();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
